// File: rtl/resource_arbiter_pkg.sv
// Shared constants, owner-index width helper and FSM states for resource_arbiter.
package resource_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_RES_LAT  = 2;
   localparam int unsigned DEF_MAX_HOLD = 8;

   // Owner index width; a single requester still needs one bit of tag.
   function automatic int unsigned owner_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-latency valid/tag shift register that follows transfers through the shared resource.
module resp_tag_pipe #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned TAG_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_any_valid
);

   logic [LAT-1:0]            r_valid;
   logic [LAT-1:0][TAG_W-1:0] r_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_tag   <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_tag[0]   <= i_tag;
         for (int i = 1; i < LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_tag[i]   <= r_tag[i-1];
         end
      end
   end

   assign o_valid     = r_valid[LAT-1];
   assign o_tag       = r_tag[LAT-1];
   assign o_any_valid = |r_valid;

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin arbiter with bounded hold in front of a fixed-latency shared resource;
// responses are routed back to their owner with a one-hot valid.
module resource_arbiter
   import resource_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned RES_LAT  = DEF_RES_LAT,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [DATA_W-1:0]         res_in,
   output logic                      res_in_valid,
   input  logic [DATA_W-1:0]         res_out,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      busy
);

   localparam int unsigned OWNER_W = owner_w(NUM_REQ);
   localparam int unsigned HOLD_W  = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [OWNER_W-1:0] RR_INIT   = OWNER_W'(NUM_REQ - 1);

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [OWNER_W-1:0]   r_owner, w_owner_nxt;
   logic [OWNER_W-1:0]   r_rr_ptr, w_rr_nxt;
   logic [HOLD_W-1:0]    r_hold, w_hold_nxt;
   logic [OWNER_W:0]     w_pick;
   logic                 w_xfer;
   logic                 w_others;
   logic [DATA_W-1:0]    w_res_in;
   logic                 w_tag_valid;
   logic [OWNER_W-1:0]   w_tag_owner;
   logic                 w_tag_any;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // First set bit of mask scanning from ptr+1 with wrap; MSB of the result flags a hit.
   function automatic logic [OWNER_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [OWNER_W-1:0] ptr);
      logic               found;
      logic [OWNER_W-1:0] sel;
      logic [NUM_REQ-1:0] sh;
      int unsigned        idx;
      found = 1'b0;
      sel   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         sh  = mask >> idx;
         if (!found && sh[0]) begin
            found = 1'b1;
            sel   = OWNER_W'(idx);
         end
      end
      return {found, sel};
   endfunction

   assign w_xfer   = |(req & r_grant);
   assign w_others = |(req & ~r_grant);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_owner  <= '0;
         r_rr_ptr <= RR_INIT;
         r_hold   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_hold   <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_ptr;
      w_hold_nxt  = r_hold;
      w_pick      = '0;
      case (r_state)
         IDLE: begin
            w_pick     = rr_pick(req, r_rr_ptr);
            w_hold_nxt = '0;
            if (w_pick[OWNER_W]) begin
               w_state_nxt = GRANT;
               w_owner_nxt = w_pick[OWNER_W-1:0];
               w_grant_nxt = onehot(w_pick[OWNER_W-1:0]);
            end else begin
               w_grant_nxt = '0;
            end
         end
         GRANT: begin
            // Owner is masked out so an expired hold always moves to someone else.
            w_pick = rr_pick(req & ~r_grant, r_owner);
            if (w_xfer && ((r_hold != HOLD_LAST) || !w_others)) begin
               if (r_hold != HOLD_LAST) begin
                  w_hold_nxt = r_hold + HOLD_W'(1);
               end
            end else if (w_pick[OWNER_W]) begin
               w_rr_nxt    = r_owner;
               w_owner_nxt = w_pick[OWNER_W-1:0];
               w_grant_nxt = onehot(w_pick[OWNER_W-1:0]);
               w_hold_nxt  = '0;
            end else begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_hold_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      w_res_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_res_in = w_res_in | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   resp_tag_pipe #(
      .LAT   (RES_LAT),
      .TAG_W (OWNER_W)
   ) u_tag_pipe (
      .clk         (clk),
      .rst_n       (reset),
      .i_valid     (w_xfer),
      .i_tag       (r_owner),
      .o_valid     (w_tag_valid),
      .o_tag       (w_tag_owner),
      .o_any_valid (w_tag_any)
   );

   assign grant        = r_grant;
   assign res_in       = w_res_in;
   assign res_in_valid = w_xfer;
   assign rsp_data     = res_out;
   assign rsp_valid    = w_tag_valid ? onehot(w_tag_owner) : '0;
   assign busy         = (|r_grant) | w_tag_any;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed-vector bench for resource_arbiter: per-cycle grant/transfer checks plus a
// response scoreboard drained by a monitor running alongside the stimulus.
module tb_resource_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 2;
   localparam int unsigned MH  = 8;

   typedef struct {
      logic [NR-1:0] vld;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    grant;
   logic [DW-1:0]    res_in;
   logic             res_in_valid;
   logic [DW-1:0]    res_out;
   logic [DW-1:0]    rsp_data;
   logic [NR-1:0]    rsp_valid;
   logic             busy;

   logic [DW-1:0] data_tab [NR] = '{32'h0000_2222, 32'hA5A5_0001, 32'h0000_1111, 32'h4444_0003};
   logic [DW-1:0] hist_d [LAT];
   logic          hist_v [LAT];
   exp_t          sb [$];
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;

   resource_arbiter #(
      .NUM_REQ  (NR),
      .DATA_W   (DW),
      .RES_LAT  (LAT),
      .MAX_HOLD (MH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .grant        (grant),
      .res_in       (res_in),
      .res_in_valid (res_in_valid),
      .res_out      (res_out),
      .rsp_data     (rsp_data),
      .rsp_valid    (rsp_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shared resource: returns what it was given LAT cycles later, garbage otherwise.
   always @(posedge clk) begin
      hist_v[0] <= res_in_valid;
      hist_d[0] <= res_in;
      for (int i = 1; i < LAT; i++) begin
         hist_v[i] <= hist_v[i-1];
         hist_d[i] <= hist_d[i-1];
      end
   end
   assign res_out = hist_v[LAT-1] ? hist_d[LAT-1] : 32'hDEAD_BEEF;

   function automatic logic [DW-1:0] data_of(input logic [NR-1:0] g);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < NR; i++) if (g[i]) d = data_tab[i];
      return d;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus: drive req, then check grant and the transfer it implies.
   task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] g_exp,
                       input logic v_exp, input bit push);
      exp_t e;
      @(negedge clk);
      req = r;
      #1;
      chk("grant", 64'(grant), 64'(g_exp));
      chk("res_in_valid", 64'(res_in_valid), 64'(v_exp));
      if (v_exp) begin
         chk("res_in", 64'(res_in), 64'(data_of(g_exp)));
         if (push) begin
            e.vld  = g_exp;
            e.data = data_of(g_exp);
            e.due  = cyc + LAT;
            sb.push_back(e);
         end
      end
   endtask

   task automatic drain();
      repeat (LAT + 2) step('0, '0, 1'b0, 1'b0);
      chk("busy_idle", 64'(busy), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      #1;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_res_in_valid", 64'(res_in_valid), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && rsp_valid !== '0) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected at cycle %0d: got valid=%b data=%h, required no response",
                        cyc, rsp_valid, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== e.vld || rsp_data !== e.data || cyc != e.due) begin
                  n_err++;
                  $display("FAIL rsp: got valid=%b data=%h cycle=%0d, required valid=%b data=%h cycle=%0d",
                           rsp_valid, rsp_data, cyc, e.vld, e.data, e.due);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      req   = '0;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = data_tab[i];
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      do_reset();

      // Reset mid-stream drops the in-flight response.
      step(4'b0001, 4'b0000, 1'b0, 1'b1);
      step(4'b0001, 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      #1;
      chk("midrst_grant", 64'(grant), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("midrst_rsp_quiet", 64'(rsp_valid), 64'(0));
      end
      drain();

      // Lone requester keeps the grant well past MAX_HOLD.
      do_reset();
      step(4'b0010, 4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) step(4'b0010, 4'b0010, 1'b1, 1'b1);
      chk("busy_active", 64'(busy), 64'(1));
      step(4'b0000, 4'b0010, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      drain();

      // Everyone requesting, each owner drops after its transfer: 0,1,2,3,0 with no gaps.
      do_reset();
      step(4'b1111, 4'b0000, 1'b0, 1'b1);
      step(4'b1111, 4'b0001, 1'b1, 1'b1);
      step(4'b1110, 4'b0001, 1'b0, 1'b1);
      step(4'b1111, 4'b0010, 1'b1, 1'b1);
      step(4'b1101, 4'b0010, 1'b0, 1'b1);
      step(4'b1111, 4'b0100, 1'b1, 1'b1);
      step(4'b1011, 4'b0100, 1'b0, 1'b1);
      step(4'b1111, 4'b1000, 1'b1, 1'b1);
      step(4'b0111, 4'b1000, 1'b0, 1'b1);
      step(4'b0001, 4'b0001, 1'b1, 1'b1);
      step(4'b0000, 4'b0001, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      drain();

      // Hold limit: two continuous requesters alternate every MAX_HOLD cycles.
      do_reset();
      step(4'b0011, 4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 3 * MH; k++)
         step(4'b0011, ((k / MH) % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1, 1'b1);
      step(4'b0000, 4'b0010, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      drain();

      // Routing: owner 2 then owner 0 on consecutive cycles at the hold boundary.
      do_reset();
      step(4'b0100, 4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < MH; k++) step(4'b0101, 4'b0100, 1'b1, 1'b1);
      step(4'b0101, 4'b0001, 1'b1, 1'b1);
      step(4'b0000, 4'b0001, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      drain();

      // Owner drops while granted: no transfer that cycle, grant moves next edge.
      do_reset();
      step(4'b0101, 4'b0000, 1'b0, 1'b1);
      step(4'b0101, 4'b0001, 1'b1, 1'b1);
      step(4'b0100, 4'b0001, 1'b0, 1'b1);
      step(4'b0100, 4'b0100, 1'b1, 1'b1);
      step(4'b0000, 4'b0100, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      drain();

      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
Responder end of the pipeline/shared-resource handshake. Up to NUM_REQ pipeline instances raise a request and drive data. The block grants exactly one requester per cycle using round-robin with bounded hold, forwards the granted data to the shared resource, and tracks ownership through the resource's fixed latency. Results are returned with a one-hot valid that tells each pipeline which response is its own.

Parameters:
NUM_REQ, 4, number of requesting pipelines (2..16)
DATA_W, 32, request and response data width
RES_LAT, 2, shared-resource latency in cycles, res_in to res_out (≥1)
MAX_HOLD, 8, max consecutive granted cycles to one owner while others wait (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-pipeline request; bit i belongs to pipeline i
req_data  in  NUM_REQ*DATA_W  pipeline i data on bits [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  registered one-hot or zero grant
res_in  out  DATA_W  data to the shared resource
res_in_valid  out  1  a transfer is occurring this cycle
res_out  in  DATA_W  shared-resource result, valid RES_LAT cycles after its res_in
rsp_data  out  DATA_W  broadcast response data (equals res_out)
rsp_valid  out  NUM_REQ  one-hot: the response this cycle belongs to pipeline i
busy  out  1  a grant is active or a response is in flight

Behaviour:
- Reset (reset=0, async): grant=0, rsp_valid=0, res_in_valid=0, busy=0, FSM=IDLE, hold_cnt=0, tag pipe cleared, rr_ptr=NUM_REQ-1 so requester 0 wins first. In-flight responses are dropped; a res_out arriving after reset release does not raise rsp_valid.
- Transfer: occurs in a cycle where grant[i]=1 and req[i]=1.
  - res_in_valid = |(grant & req), combinational.
  - res_in = req_data slice of the current owner, else 0.
- FSM IDLE: if req != 0, select the first set bit scanning from rr_ptr+1 with wrap. Register grant=onehot(sel) and owner=sel; go to GRANT. hold_cnt=0. Otherwise grant stays 0.
- FSM GRANT, evaluated each cycle on current req:
  - Keep: req[owner]=1 and (hold_cnt<MAX_HOLD-1 or no other req). Keep owner and increment hold_cnt. If no others are waiting, saturate hold_cnt at MAX_HOLD-1 and never force rotation.
  - Rotate: req[owner]=0, or hold_cnt==MAX_HOLD-1 with another req pending. Set rr_ptr=owner and pick the next requester from owner+1 with wrap, excluding owner when hold expired. Register the new grant with no idle bubble and reset hold_cnt=0.
  - If no req remains, go to IDLE with grant=0.
- Requester drop: a pipeline deasserting req while granted loses that cycle; grant is still high but no transfer happens. Grant moves on the next edge.
- Grant never changes combinationally; it changes only at clock edges. At most one bit is ever set.
- Tag pipe: RES_LAT-deep shift of {valid, owner_idx}; stage 0 loads {res_in_valid, owner} each cycle.
  - rsp_valid = valid_out ? onehot(owner_out) : 0.
  - rsp_data = res_out, passed through.
- Back-to-back transfers fill consecutive stages; ordering is preserved; there is no backpressure on responses.
- busy = (grant!=0) | any tag-pipe valid.
- Simultaneous requests with all bits set rotate 0,1,2,3,0,… whenever each owner drops req after one transfer.
- owner index width = $clog2(NUM_REQ); for NUM_REQ=1 it is forced to 1.

Decomposition:
- Package resource_arbiter_pkg holds:
  - default parameter constants;
  - OWNER_W localparam function;
  - FSM state enum (IDLE, GRANT).
- Sub-module resp_tag_pipe: a parameterised RES_LAT-deep valid/tag shift register with async active-low reset.
- The round-robin pick is a function inside resource_arbiter.

Test Plan:
1. Reset mid-stream: req=0001, transfer at cycle t, assert reset at t+1 → grant=0, rsp_valid stays 0 at t+RES_LAT, busy=0.
2. Single requester: req=0010 held, data 0xA5A5_0001 → grant=0010 from the second edge. res_in_valid=1 every cycle, no forced rotation after 8+ cycles, rsp_valid=0010 exactly RES_LAT cycles after each transfer.
3. All requesting, each drops after one granted cycle → grant sequence 0001,0010,0100,1000,0001 with no idle cycles.
4. Hold limit: req=0011 held continuously, MAX_HOLD=8 → owner 0 granted 8 cycles, then owner 1 granted 8 cycles, alternating.
5. Response routing: transfers from owners 2 then 0 on consecutive cycles, res_out=0x1111/0x2222 at the matching latency → rsp_valid=0100 with 0x1111, then 0001 with 0x2222.
6. Owner drops req while granted, req=0101 → that cycle has res_in_valid=0, and grant moves to 0100 on the next edge.
